nand_response_checker: RTL

Synthesizable response checker for the integer-ALU NAND unit: the receiving end of a NAND stimulus stream. It accepts (A, B, result) triples over a valid/ready handshake and compares each result against the golden bitwise NAND. It counts passes and fails over a fixed-length run, and captures the first failing vector. It sits on-chip between a vector source (bench driver or BIST sequencer) and the status registers, so NAND checking does not depend on `$monitor` inspection.

---
 rtl/nand_response_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nand_response_checker.sv
// Receiving end of a NAND stimulus stream: checks each accepted (a, b, y) triple
// against ~(a & b), counts passes/fails for one run and captures the first failure.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start after reset; no triples accepted
//   S_RUN  | accepting triples until NUM_VECTORS have been taken
//   S_DONE | run complete; results held until the next start
module nand_response_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic [CNT_W-1:0] ff_idx,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_y,
  output logic [WIDTH-1:0] ff_mask
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic [WIDTH-1:0] ff_y_q, ff_y_d;
  logic [WIDTH-1:0] ff_mask_q, ff_mask_d;

  logic             accept;
  logic [WIDTH-1:0] expected;

  // in_ready comes from state only, so the source never sees a comb path back
  assign accept   = in_valid && (state_q == S_RUN);
  assign expected = ~(a & b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      error_q   <= 1'b0;
      ff_idx_q  <= '0;
      ff_a_q    <= '0;
      ff_b_q    <= '0;
      ff_y_q    <= '0;
      ff_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      error_q   <= error_d;
      ff_idx_q  <= ff_idx_d;
      ff_a_q    <= ff_a_d;
      ff_b_q    <= ff_b_d;
      ff_y_q    <= ff_y_d;
      ff_mask_q <= ff_mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    error_d   = error_q;
    ff_idx_d  = ff_idx_q;
    ff_a_d    = ff_a_q;
    ff_b_d    = ff_b_q;
    ff_y_d    = ff_y_q;
    ff_mask_d = ff_mask_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          idx_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          error_d   = 1'b0;
          ff_idx_d  = '0;
          ff_a_d    = '0;
          ff_b_d    = '0;
          ff_y_d    = '0;
          ff_mask_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (idx_q != CNT_MAX) idx_d = idx_q + 1'b1;
          // written as match/else so an unknown y lands in the fail branch
          if (y == expected) begin
            if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
            if (!error_q) begin
              error_d   = 1'b1;
              ff_idx_d  = idx_q;
              ff_a_d    = a;
              ff_b_d    = b;
              ff_y_d    = y;
              ff_mask_d = y ^ expected;
            end
          end
          if (idx_q == LAST_IDX) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign error    = error_q;
  assign ff_idx   = ff_idx_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_y     = ff_y_q;
  assign ff_mask  = ff_mask_q;

endmodule
